// File: rtl/movement_pkg.sv
`default_nettype none
// ============================================================================
// movement_pkg : axis FSM state and direction encodings shared by the 2-D mover
// Revision     : 1.0
// ============================================================================
package movement_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } axis_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } dir_t;

  // Opposing requests on one axis cancel out.
  function automatic dir_t decode_dir(input logic pos_req, input logic neg_req);
    if (pos_req && !neg_req) return POS;
    if (neg_req && !pos_req) return NEG;
    return NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_stepper.sv
`default_nettype none
// ============================================================================
// axis_stepper : one-axis IDLE/SLOW/FAST stepper with bounded position update
//                (MOVE_WRAP_EN: wrap to the opposite bound instead of saturating)
// Revision     : 1.0
// ============================================================================
module axis_stepper
  import movement_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MIN        = 0,
  parameter int MAX        = 255,
  parameter int INIT       = 0,
  parameter int STEP       = 1,
  parameter int FAST_STEP  = 4,
  parameter int HOLD_TICKS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_pos_req,
  input  logic             i_neg_req,
  output logic [WIDTH-1:0] o_val,
  output logic             o_at_edge,
  output logic             o_changed
);

  localparam int HC_W = $clog2(HOLD_TICKS + 1);

  localparam logic [WIDTH:0]   c_min       = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0]   c_max       = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   c_step      = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   c_fast_step = (WIDTH+1)'(FAST_STEP);
  localparam logic [WIDTH-1:0] c_min_w     = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] c_max_w     = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_init      = WIDTH'(INIT);
  localparam logic             c_init_edge = (INIT == MIN) || (INIT == MAX);
  localparam logic [HC_W-1:0]  c_hold_max  = HC_W'(HOLD_TICKS);
  localparam logic [HC_W-1:0]  c_hold_one  = HC_W'(1);

`ifdef MOVE_WRAP_EN
  localparam logic [WIDTH-1:0] c_over_val  = c_min_w;
  localparam logic [WIDTH-1:0] c_under_val = c_max_w;
`else
  localparam logic [WIDTH-1:0] c_over_val  = c_max_w;
  localparam logic [WIDTH-1:0] c_under_val = c_min_w;
`endif

  axis_state_t      r_state;
  dir_t             r_dir;
  logic [HC_W-1:0]  r_hold;
  logic [WIDTH-1:0] r_val;
  logic             r_edge;
  logic             r_changed;

  dir_t             w_dir;
  axis_state_t      w_state_nxt;
  dir_t             w_dir_nxt;
  logic [HC_W-1:0]  w_hold_nxt;
  logic [HC_W-1:0]  w_hold_inc;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_val_nxt;

  always_comb begin
    w_dir       = decode_dir(i_pos_req, i_neg_req);
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_hold_nxt  = r_hold;
    w_step      = '0;
    w_hold_inc  = (r_hold == c_hold_max) ? r_hold : r_hold + 1'b1;
    if (w_dir == NONE) begin
      w_state_nxt = IDLE;
      w_dir_nxt   = NONE;
      w_hold_nxt  = '0;
    end else if (r_state == IDLE || w_dir != r_dir) begin
      w_state_nxt = SLOW;
      w_dir_nxt   = w_dir;
      w_hold_nxt  = c_hold_one;
      w_step      = c_step;
    end else if (r_state == SLOW) begin
      w_hold_nxt  = w_hold_inc;
      w_step      = c_step;
      if (w_hold_inc == c_hold_max) w_state_nxt = FAST;
    end else begin
      w_step      = c_fast_step;
    end
  end

  // One spare bit makes both overflow past MAX and borrow below zero visible.
  always_comb begin
    w_ext     = {1'b0, r_val};
    w_sum     = w_ext + w_step;
    w_diff    = w_ext - w_step;
    w_val_nxt = r_val;
    if (w_step != '0) begin
      if (w_dir == POS) begin
        w_val_nxt = (w_sum > c_max) ? c_over_val : w_sum[WIDTH-1:0];
      end else begin
        w_val_nxt = (w_diff[WIDTH] || (w_diff < c_min)) ? c_under_val : w_diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_dir     <= NONE;
      r_hold    <= '0;
      r_val     <= c_init;
      r_edge    <= c_init_edge;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (i_tick) begin
        r_state   <= w_state_nxt;
        r_dir     <= w_dir_nxt;
        r_hold    <= w_hold_nxt;
        r_val     <= w_val_nxt;
        r_edge    <= (w_val_nxt == c_min_w) || (w_val_nxt == c_max_w);
        r_changed <= (w_val_nxt != r_val);
      end
    end
  end

  assign o_val     = r_val;
  assign o_at_edge = r_edge;
  assign o_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/movement_ctrl_2d.sv
`default_nettype none
// ============================================================================
// movement_ctrl_2d : tick-paced 2-D position controller (x: left/right, y: down/up)
//                    MOVE_WRAP_EN selects wrap-around at the bounds
// Revision         : 1.0
// ============================================================================
module movement_ctrl_2d
  import movement_pkg::*;
#(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 8,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 255,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 255,
  parameter int X_INIT     = 0,
  parameter int Y_INIT     = 0,
  parameter int TICK_DIV   = 25000000,
  parameter int STEP       = 1,
  parameter int FAST_STEP  = 4,
  parameter int HOLD_TICKS = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  output logic [X_WIDTH-1:0] x_val,
  output logic [Y_WIDTH-1:0] y_val,
  output logic               moved,
  output logic               x_edge,
  output logic               y_edge
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_reload = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic             w_x_changed;
  logic             w_y_changed;

  // Tick is a clock enable, never a derived clock; a disabled counter freezes everything.
  assign w_tick = enable && (r_tick_cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tick_cnt <= c_reload;
    end else if (enable) begin
      r_tick_cnt <= w_tick ? c_reload : r_tick_cnt - 1'b1;
    end
  end

  axis_stepper #(
    .WIDTH(X_WIDTH), .MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT),
    .STEP(STEP), .FAST_STEP(FAST_STEP), .HOLD_TICKS(HOLD_TICKS)
  ) u_x_axis (
    .clock     (clock),
    .reset     (reset),
    .i_tick    (w_tick),
    .i_pos_req (right),
    .i_neg_req (left),
    .o_val     (x_val),
    .o_at_edge (x_edge),
    .o_changed (w_x_changed)
  );

  axis_stepper #(
    .WIDTH(Y_WIDTH), .MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT),
    .STEP(STEP), .FAST_STEP(FAST_STEP), .HOLD_TICKS(HOLD_TICKS)
  ) u_y_axis (
    .clock     (clock),
    .reset     (reset),
    .i_tick    (w_tick),
    .i_pos_req (up),
    .i_neg_req (down),
    .o_val     (y_val),
    .o_at_edge (y_edge),
    .o_changed (w_y_changed)
  );

  assign moved = w_x_changed | w_y_changed;

endmodule
`default_nettype wire
